bram_dual: RTL and testbench
============================

# bram_dual

True dual-port block RAM with per-byte write masks, selectable read latency (1 or 2 cycles) and an optional post-reset clear sequencer. It replaces the single-port BRAM wherever two masters share one memory, e.g. CPU data port against a DMA or video fetch port. Both ports are fully pipelined and accept one request per cycle. Each request is answered with a `ready` strobe carrying a bounds-check `valid` flag.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `SIZE`, 32'h400: depth in words.
- `ADDR_LSH`, 2: right shift from byte address to word index.
- `LATENCY`, 1: request-to-`o_x_ready` latency. Legal values are 1 (unregistered array output) and 2 (extra output register). Any other value is an elaboration error.
- `CLEAR_ON_RESET`, 1: when 1, zero every word after reset before accepting requests.

- `i_clock`  in  1  sole clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `o_busy`  out  1  high while the clear sequence runs; requests are ignored.
- `i_a_request`  in  1  port A request strobe, sampled every cycle.
- `i_a_rw`  in  1  0 = read, 1 = write.
- `i_a_address`  in  32  byte address.
- `i_a_wdata`  in  WIDTH  write data.
- `i_a_wmask`  in  WIDTH/8  byte enables; bit n enables `wdata[8n+7:8n]`.
- `o_a_rdata`  out  WIDTH  read data.
- `o_a_ready`  out  1  one-cycle completion strobe.
- `o_a_valid`  out  1  address was in range; meaningful only while `o_a_ready` is high.
- `i_b_*` / `o_b_*`: identical set for port B.

## Operation
**Index and range**
- idx = `address >> ADDR_LSH`.
- Request is in range iff idx < SIZE.
- An out-of-range request does not write, returns `rdata` = 0 and `valid` = 0, and still produces `ready`.

**Accepted request**
- A request is accepted when `request` = 1 and `o_busy` = 0.
- Requests arriving while busy are dropped: no `ready` and no write.

**Writes**
- Only bytes with mask bit 1 are updated.
- A mask of all zeros is a legal no-op write and still gets `ready`/`valid`.

**Reads**
- Return the word as it was before any write in the same cycle, on either port (read-first).

**Write collision**
- Both ports write the same idx in the same cycle: port A's enabled bytes win.
- Port B's bytes are applied only where port A's mask bit is 0.

**Clear FSM** (states `CLEAR`, `RUN`)
- Reset enters `CLEAR` with the counter at 0 if `CLEAR_ON_RESET` = 1, otherwise enters `RUN`.
- In `CLEAR`: write 0 to word[counter] and increment. After writing word SIZE-1, go to `RUN`.
- `o_busy` = 1 exactly while in `CLEAR`, i.e. for SIZE cycles.
- Reset asserted mid-clear restarts the clear from index 0.

**Reset, all outputs**
- `o_x_ready` = 0, `o_x_valid` = 0, `o_x_rdata` = 0.
- The pipeline is flushed: requests accepted before reset never produce `ready`.
- Without a clear, memory contents are not affected by reset.

## Timing
- Request accepted at edge N: `o_x_ready` is high for exactly cycle N+LATENCY, with `rdata`/`valid` valid in that same cycle.
- Back-to-back requests produce back-to-back `ready` strobes in the same order. There is no stall and no backpressure.
- A write is visible to a read on either port issued at edge N+1 or later.
- `o_x_rdata` holds its last value when `ready` = 0, except after reset, when it is 0.
- With `LATENCY` = 2, `rdata` and `valid` are both registered a second time. Ports stay independent; port A's timing never depends on port B.
- First request accepted after reset is at the edge following:
  - the cycle where `o_busy` falls, when `CLEAR_ON_RESET` = 1;
  - the reset deassert, when `CLEAR_ON_RESET` = 0.

## Test plan
- **Clear:** `SIZE`=16, `CLEAR_ON_RESET`=1.
  - Fill memory with 0xFFFFFFFF, then assert reset.
  - Required: `o_busy` high for 16 cycles.
  - Required: reads of idx 0..15 all return 0 with `valid`=1.
- **Byte mask:**
  - Write 0x11223344 full mask to 0x10, then 0xAABBCCDD with mask 4'b0101 to 0x10.
  - Required: read returns 0x11BB33DD after 1 cycle (`LATENCY`=1) or 2 cycles (`LATENCY`=2).
- **Collision:** same cycle, A writes 0x000000AA mask 4'b0001 to idx 5, B writes 0x12345678 full mask to idx 5.
  - Required: idx 5 reads back 0x123456AA.
- **Read-first:** A reads idx 3 (holding 0x1) in the same cycle that B writes 0x2 there.
  - Required: A returns 0x1; the next A read returns 0x2.
- **Bounds:** `SIZE`=0x400, `ADDR_LSH`=2; read and write at address 0x1000.
  - Required: `ready`=1, `valid`=0, `rdata`=0; idx 0 unchanged.
- **Pipelining and flush:**
  - 8 consecutive reads on A, idx 0..7, with `LATENCY`=2: 8 consecutive `ready` strobes in order.
  - Reset asserted after the 3rd accept: no further `ready` strobes for the pending requests.

Source files
------------

// File: rtl/bram_dual.sv
// True dual-port block RAM with per-byte write masks, read-first ports,
// selectable 1/2-cycle read latency and an optional post-reset clear pass.
module bram_dual #(
   parameter int WIDTH          = 32,
   parameter int SIZE           = 32'h400,
   parameter int ADDR_LSH       = 2,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   output logic               o_busy,

   input  logic               i_a_request,
   input  logic               i_a_rw,
   input  logic [31:0]        i_a_address,
   input  logic [WIDTH-1:0]   i_a_wdata,
   input  logic [WIDTH/8-1:0] i_a_wmask,
   output logic [WIDTH-1:0]   o_a_rdata,
   output logic               o_a_ready,
   output logic               o_a_valid,

   input  logic               i_b_request,
   input  logic               i_b_rw,
   input  logic [31:0]        i_b_address,
   input  logic [WIDTH-1:0]   i_b_wdata,
   input  logic [WIDTH/8-1:0] i_b_wmask,
   output logic [WIDTH-1:0]   o_b_rdata,
   output logic               o_b_ready,
   output logic               o_b_valid
);

   localparam int NB = WIDTH / 8;
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

   generate
      if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
         $error("bram_dual: LATENCY must be 1 or 2");
      end
      if (WIDTH % 8 != 0) begin : g_bad_width
         $error("bram_dual: WIDTH must be a multiple of 8");
      end
   endgenerate

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [IW-1:0]   cnt;
   logic [IW-1:0]   cnt_nx;
   logic            clr_we;
   logic            busy;

   // Port 0 is A, port 1 is B.
   logic [1:0]       req;
   logic [1:0]       rw;
   logic [31:0]      addr  [2];
   logic [WIDTH-1:0] wdata [2];
   logic [NB-1:0]    wmask [2];

   logic [31:0]      idx   [2];
   logic [IW-1:0]    widx  [2];
   logic [1:0]       in_range;
   logic [1:0]       acc;
   logic [1:0]       we;

   logic [WIDTH-1:0] mem [SIZE];

   logic [1:0]       vld_p0;
   logic [1:0]       ok_p0;
   logic [WIDTH-1:0] rdata_p0 [2];

   assign req      = {i_b_request, i_a_request};
   assign rw       = {i_b_rw, i_a_rw};
   assign addr[0]  = i_a_address;
   assign addr[1]  = i_b_address;
   assign wdata[0] = i_a_wdata;
   assign wdata[1] = i_b_wdata;
   assign wmask[0] = i_a_wmask;
   assign wmask[1] = i_b_wmask;

   assign busy   = (state == CLEAR);
   assign o_busy = busy;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         idx[p]      = addr[p] >> ADDR_LSH;
         widx[p]     = idx[p][IW-1:0];
         in_range[p] = (idx[p] < 32'(SIZE));
         // A request on the reset edge belongs to the flushed pipeline.
         acc[p]      = req[p] & ~busy & ~i_reset;
         we[p]       = acc[p] & rw[p] & in_range[p];
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         if (CLEAR_ON_RESET) begin
            state <= CLEAR;
         end else begin
            state <= RUN;
         end
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr_we   = 1'b0;
      case (state)
         CLEAR: begin
            clr_we = ~i_reset;
            cnt_nx = cnt + 1'b1;
            if (cnt == IW'(SIZE - 1)) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end
         end
         default: begin
         end
      endcase
   end

   // Port B is applied first so that port A's enabled bytes overwrite it.
   always_ff @(posedge i_clock) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end
      for (int p = 1; p >= 0; p--) begin
         if (we[p]) begin
            for (int b = 0; b < NB; b++) begin
               if (wmask[p][b]) begin
                  mem[widx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
               end
            end
         end
      end
   end

   // Stage p0: array read (old contents, read-first) and range flag.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         vld_p0 <= '0;
         ok_p0  <= '0;
         for (int p = 0; p < 2; p++) begin
            rdata_p0[p] <= '0;
         end
      end else begin
         vld_p0 <= acc;
         for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
               ok_p0[p]    <= in_range[p];
               rdata_p0[p] <= in_range[p] ? mem[widx[p]] : '0;
            end
         end
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic [1:0]       vld_p1;
         logic [1:0]       ok_p1;
         logic [WIDTH-1:0] rdata_p1 [2];

         // Stage p1: optional output register, holds data between strobes.
         always_ff @(posedge i_clock) begin
            if (i_reset) begin
               vld_p1 <= '0;
               ok_p1  <= '0;
               for (int p = 0; p < 2; p++) begin
                  rdata_p1[p] <= '0;
               end
            end else begin
               vld_p1 <= vld_p0;
               for (int p = 0; p < 2; p++) begin
                  if (vld_p0[p]) begin
                     ok_p1[p]    <= ok_p0[p];
                     rdata_p1[p] <= rdata_p0[p];
                  end
               end
            end
         end

         assign o_a_ready = vld_p1[0];
         assign o_a_valid = ok_p1[0];
         assign o_a_rdata = rdata_p1[0];
         assign o_b_ready = vld_p1[1];
         assign o_b_valid = ok_p1[1];
         assign o_b_rdata = rdata_p1[1];
      end else begin : g_lat1
         assign o_a_ready = vld_p0[0];
         assign o_a_valid = ok_p0[0];
         assign o_a_rdata = rdata_p0[0];
         assign o_b_ready = vld_p0[1];
         assign o_b_valid = ok_p0[1];
         assign o_b_rdata = rdata_p0[1];
      end
   endgenerate

endmodule

// File: tb/tb_bram_dual.sv
// Directed bench for bram_dual: a 16-word clearing instance at latency 1 and
// a 1K-word non-clearing instance at latency 2, driven from one clock.
module tb_bram_dual;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Small instance: SIZE 16, LATENCY 1, clear on reset.
   logic        s_rst;
   logic        s_busy;
   logic [1:0]  s_req;
   logic [1:0]  s_rw;
   logic [31:0] s_addr  [2];
   logic [31:0] s_wdata [2];
   logic [3:0]  s_wmask [2];
   logic [31:0] s_rdata [2];
   logic [1:0]  s_ready;
   logic [1:0]  s_valid;

   // Large instance: SIZE 0x400, LATENCY 2, no clear.
   logic        l_rst;
   logic        l_busy;
   logic [1:0]  l_req;
   logic [1:0]  l_rw;
   logic [31:0] l_addr  [2];
   logic [31:0] l_wdata [2];
   logic [3:0]  l_wmask [2];
   logic [31:0] l_rdata [2];
   logic [1:0]  l_ready;
   logic [1:0]  l_valid;

   bram_dual #(.WIDTH(32), .SIZE(16), .ADDR_LSH(2), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_small (
      .i_clock(clk), .i_reset(s_rst), .o_busy(s_busy),
      .i_a_request(s_req[0]), .i_a_rw(s_rw[0]), .i_a_address(s_addr[0]),
      .i_a_wdata(s_wdata[0]), .i_a_wmask(s_wmask[0]),
      .o_a_rdata(s_rdata[0]), .o_a_ready(s_ready[0]), .o_a_valid(s_valid[0]),
      .i_b_request(s_req[1]), .i_b_rw(s_rw[1]), .i_b_address(s_addr[1]),
      .i_b_wdata(s_wdata[1]), .i_b_wmask(s_wmask[1]),
      .o_b_rdata(s_rdata[1]), .o_b_ready(s_ready[1]), .o_b_valid(s_valid[1])
   );

   bram_dual #(.WIDTH(32), .SIZE(32'h400), .ADDR_LSH(2), .LATENCY(2), .CLEAR_ON_RESET(1'b0)) u_large (
      .i_clock(clk), .i_reset(l_rst), .o_busy(l_busy),
      .i_a_request(l_req[0]), .i_a_rw(l_rw[0]), .i_a_address(l_addr[0]),
      .i_a_wdata(l_wdata[0]), .i_a_wmask(l_wmask[0]),
      .o_a_rdata(l_rdata[0]), .o_a_ready(l_ready[0]), .o_a_valid(l_valid[0]),
      .i_b_request(l_req[1]), .i_b_rw(l_rw[1]), .i_b_address(l_addr[1]),
      .i_b_wdata(l_wdata[1]), .i_b_wmask(l_wmask[1]),
      .o_b_rdata(l_rdata[1]), .o_b_ready(l_ready[1]), .o_b_valid(l_valid[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s_set(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      s_req[p] = 1'b1; s_rw[p] = w; s_addr[p] = a; s_wdata[p] = d; s_wmask[p] = m;
   endtask

   task automatic l_set(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      l_req[p] = 1'b1; l_rw[p] = w; l_addr[p] = a; l_wdata[p] = d; l_wmask[p] = m;
   endtask

   // One request on the latency-1 instance; outputs are current on return.
   task automatic s_op(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      s_set(p, w, a, d, m);
      tick();
      s_req = 2'b00;
   endtask

   task automatic s_read(input int p, input logic [31:0] a, input logic [31:0] exp, input string tag);
      s_op(p, 1'b0, a, 32'h0, 4'h0);
      check(tag, {s_ready[p], s_valid[p], s_rdata[p]}, {1'b1, 1'b1, exp});
   endtask

   // One request on the latency-2 instance; ready must not appear early.
   task automatic l_op(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      l_set(p, w, a, d, m);
      tick();
      l_req = 2'b00;
      check("l_early_ready", l_ready[p], 1'b0);
      tick();
   endtask

   initial begin
      int n;
      logic       late;
      logic [1:0] seen;

      s_rst = 1'b1; l_rst = 1'b1; s_req = '0; l_req = '0; s_rw = '0; l_rw = '0;
      for (int p = 0; p < 2; p++) begin
         s_addr[p] = '0; s_wdata[p] = '0; s_wmask[p] = '0;
         l_addr[p] = '0; l_wdata[p] = '0; l_wmask[p] = '0;
      end
      tick();
      tick();
      check("s_reset_out", {s_ready, s_valid, s_rdata[0], s_rdata[1]}, 64'h0);
      check("l_reset_out", {l_ready, l_valid, l_rdata[0], l_rdata[1]}, 64'h0);
      check("s_busy_in_reset", s_busy, 1'b1);
      check("l_busy_no_clear", l_busy, 1'b0);

      s_rst = 1'b0; l_rst = 1'b0;
      n = 0;
      while (s_busy && n < 100) begin n++; tick(); end
      check("s_busy_cycles", n, 16);

      // Fill with all ones, then clear again with a reset mid-way.
      for (int i = 0; i < 16; i++) s_op(i % 2, 1'b1, 32'(i * 4), 32'hFFFF_FFFF, 4'hF);
      s_read(0, 32'h3C, 32'hFFFF_FFFF, "s_fill");

      s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      s_set(0, 1'b1, 32'h0, 32'h77, 4'hF);
      seen = '0;
      for (int i = 0; i < 5; i++) begin tick(); seen = seen | s_ready; end
      s_req = 2'b00;
      check("s_drop_while_busy", seen, 2'b00);
      s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      n = 0;
      while (s_busy && n < 100) begin n++; tick(); end
      check("s_busy_restart", n, 16);
      for (int i = 0; i < 16; i++) s_read(i % 2, 32'(i * 4), 32'h0, $sformatf("s_clear_rd%0d", i));

      // Byte mask and hold.
      s_op(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
      s_op(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
      s_read(0, 32'h10, 32'h11BB_33DD, "s_mask");
      tick();
      check("s_hold", {s_ready[0], s_rdata[0]}, {1'b0, 32'h11BB_33DD});

      // Same-cycle write collision on idx 5.
      s_set(0, 1'b1, 32'h14, 32'h0000_00AA, 4'b0001);
      s_set(1, 1'b1, 32'h14, 32'h1234_5678, 4'hF);
      tick();
      s_req = 2'b00;
      check("s_collide_rdy", {s_ready, s_valid}, 4'b1111);
      s_read(1, 32'h14, 32'h1234_56AA, "s_collide");

      // Read-first in both directions on idx 3.
      s_op(1, 1'b1, 32'hC, 32'h1, 4'hF);
      s_set(0, 1'b0, 32'hC, 32'h0, 4'h0);
      s_set(1, 1'b1, 32'hC, 32'h2, 4'hF);
      tick();
      s_req = 2'b00;
      check("s_rf_a_old", {s_ready[0], s_rdata[0]}, {1'b1, 32'h1});
      s_read(0, 32'hC, 32'h2, "s_rf_a_new");
      s_set(1, 1'b0, 32'hC, 32'h0, 4'h0);
      s_set(0, 1'b1, 32'hC, 32'h3, 4'hF);
      tick();
      s_req = 2'b00;
      check("s_rf_b_old", {s_ready[1], s_rdata[1]}, {1'b1, 32'h2});
      s_read(1, 32'hC, 32'h3, "s_rf_b_new");

      // Large instance: back-to-back writes then 8 pipelined reads.
      for (int i = 0; i < 8; i++) begin
         l_set(0, 1'b1, 32'(i * 4), 32'h100 + 32'(i), 4'hF);
         tick();
      end
      l_req = 2'b00;
      tick(); tick(); tick();
      for (int i = 0; i < 10; i++) begin
         if (i < 8) l_set(0, 1'b0, 32'(i * 4), 32'h0, 4'h0);
         else l_req = 2'b00;
         tick();
         if (i >= 1 && i <= 8)
            check($sformatf("l_pipe%0d", i - 1), {l_ready[0], l_valid[0], l_rdata[0]},
                  {1'b1, 1'b1, 32'h100 + 32'(i - 1)});
         else
            check($sformatf("l_pipe_idle%0d", i), l_ready[0], 1'b0);
      end

      l_op(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
      l_op(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
      l_op(0, 1'b0, 32'h10, 32'h0, 4'h0);
      check("l_mask", {l_ready[0], l_valid[0], l_rdata[0]}, {1'b1, 1'b1, 32'h11BB_33DD});

      // Bounds: idx 0x400 is out of range, idx 0x3FF is the last word.
      l_op(0, 1'b1, 32'h0, 32'h55, 4'hF);
      l_op(1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
      check("l_oob_wr", {l_ready[1], l_valid[1], l_rdata[1]}, {1'b1, 1'b0, 32'h0});
      l_op(0, 1'b0, 32'h1000, 32'h0, 4'h0);
      check("l_oob_rd", {l_ready[0], l_valid[0], l_rdata[0]}, {1'b1, 1'b0, 32'h0});
      l_op(1, 1'b0, 32'h0, 32'h0, 4'h0);
      check("l_oob_idx0", {l_ready[1], l_valid[1], l_rdata[1]}, {1'b1, 1'b1, 32'h55});
      l_op(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF);
      l_op(1, 1'b0, 32'hFFC, 32'h0, 4'h0);
      check("l_top_word", {l_ready[1], l_valid[1], l_rdata[1]}, {1'b1, 1'b1, 32'hCAFE_F00D});

      // Flush: reset right after the third accepted read.
      seen = '0;
      for (int i = 0; i < 3; i++) begin
         l_set(0, 1'b0, 32'(i * 4), 32'h0, 4'h0);
         tick();
         if (i > 0) seen[i-1] = l_ready[0];
      end
      l_req = 2'b00;
      check("l_flush_pre", seen, 2'b11);
      l_rst = 1'b1;
      tick();
      check("l_flush_out", {l_ready, l_rdata[0]}, 34'h0);
      l_rst = 1'b0;
      late = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); late = late | l_ready[0]; end
      check("l_flush_none", late, 1'b0);
      l_op(0, 1'b0, 32'h4, 32'h0, 4'h0);
      check("l_keep_mem", {l_ready[0], l_valid[0], l_rdata[0]}, {1'b1, 1'b1, 32'h101});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
